// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencing controller: state encoding,
// opcodes and the default ALU wait limit.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_e;

   localparam logic [1:0] OP_ALU0 = 2'b00;
   localparam logic [1:0] OP_ALU1 = 2'b01;
   localparam logic [1:0] OP_BR   = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam int unsigned ALU_TIMEOUT_DEF = 15;

   localparam int unsigned RETIRED_W = 16;

   function automatic logic is_busy_state(state_e s);
      return (s != ST_IDLE) && (s != ST_HALT);
   endfunction

endpackage

// File: rtl/cpu_controller_alu_timeout_counter.sv
// Counts EXECUTE cycles spent without alu_done; tc flags the cycle in which
// the count reaches LIMIT.
module alu_timeout_counter #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Saturates at the terminal value so it can never wrap.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !tc) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute/writeback sequencer; all outputs are registered and
// each strobe is computed from the state the FSM is about to enter.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int unsigned INSTRUCTION_WIDTH = 16,
   parameter int unsigned DATA_WIDTH        = 16,
   parameter int unsigned ALU_TIMEOUT       = ALU_TIMEOUT_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
   input  logic                         alu_done,
   input  logic [DATA_WIDTH-1:0]        alu_result,
   output logic                         en_pc,
   output logic                         alu_start,
   output logic [1:0]                   alu_op,
   output logic                         reg_we,
   output logic [DATA_WIDTH-1:0]        last_alu_result,
   output logic [15:0]                  retired_count,
   output logic                         busy,
   output logic                         halted,
   output logic                         timeout_err,
   output logic [2:0]                   state
);

   state_e                       state_q, state_d;
   logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0]        last_q, last_d;
   logic [RETIRED_W-1:0]         retired_q, retired_d;
   logic                         timeout_q, timeout_d;
   logic                         en_pc_q, en_pc_d;
   logic                         alu_start_q, alu_start_d;
   logic [1:0]                   alu_op_q, alu_op_d;
   logic                         reg_we_q, reg_we_d;
   logic                         busy_q, busy_d;
   logic                         halted_q, halted_d;

   logic cnt_clear;
   logic cnt_enable;
   logic cnt_tc;

   alu_timeout_counter #(
      .LIMIT (ALU_TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .tc     (cnt_tc)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      last_d    = last_q;
      retired_d = retired_q;
      timeout_d = timeout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = instruction_in;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            unique case (ir_q[1:0])
               OP_BR: begin
                  retired_d = retired_q + RETIRED_W'(1);
                  state_d   = ST_FETCH;
               end
               OP_HALT: state_d = ST_HALT;
               default: state_d = ST_EXECUTE;
            endcase
         end
         ST_EXECUTE: begin
            if (alu_done) begin
               last_d  = alu_result;
               state_d = ST_WRITEBACK;
            end else if (cnt_tc) begin
               timeout_d = 1'b1;
               state_d   = ST_HALT;
            end
         end
         ST_WRITEBACK: begin
            retired_d = retired_q + RETIRED_W'(1);
            state_d   = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs describe the state being entered.
   always_comb begin
      en_pc_d     = ((state_d == ST_DECODE) && (ir_d[1:0] == OP_BR))
                    || (state_d == ST_WRITEBACK);
      alu_start_d = (state_d == ST_EXECUTE) && (state_q != ST_EXECUTE);
      alu_op_d    = (state_d == ST_EXECUTE) ? ir_d[1:0] : 2'b00;
      reg_we_d    = (state_d == ST_WRITEBACK);
      busy_d      = is_busy_state(state_d);
      halted_d    = (state_d == ST_HALT);
      cnt_clear   = alu_start_d;
      cnt_enable  = (state_q == ST_EXECUTE) && !alu_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         last_q      <= '0;
         retired_q   <= '0;
         timeout_q   <= 1'b0;
         en_pc_q     <= 1'b0;
         alu_start_q <= 1'b0;
         alu_op_q    <= 2'b00;
         reg_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         last_q      <= last_d;
         retired_q   <= retired_d;
         timeout_q   <= timeout_d;
         en_pc_q     <= en_pc_d;
         alu_start_q <= alu_start_d;
         alu_op_q    <= alu_op_d;
         reg_we_q    <= reg_we_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   // Operand fields of ir are decoded elsewhere; only the opcode matters here.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir_q[INSTRUCTION_WIDTH-1:2];

   assign en_pc           = en_pc_q;
   assign alu_start       = alu_start_q;
   assign alu_op          = alu_op_q;
   assign reg_we          = reg_we_q;
   assign last_alu_result = last_q;
   assign retired_count   = retired_q;
   assign busy            = busy_q;
   assign halted          = halted_q;
   assign timeout_err     = timeout_q;
   assign state           = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed table-driven bench for cpu_controller plus hand-written timeout,
// done-at-limit and reset-mid-operation sequences.
module tb_cpu_controller;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                          S_EXE = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [15:0] instruction_in = '0;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic        en_pc, alu_start, reg_we, busy, halted, timeout_err;
   logic [1:0]  alu_op;
   logic [15:0] last_alu_result, retired_count;
   logic [2:0]  state;

   int tests = 0;
   int failed = 0;

   cpu_controller #(
      .INSTRUCTION_WIDTH (16),
      .DATA_WIDTH        (16),
      .ALU_TIMEOUT       (15)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .run             (run),
      .instruction_in  (instruction_in),
      .alu_done        (alu_done),
      .alu_result      (alu_result),
      .en_pc           (en_pc),
      .alu_start       (alu_start),
      .alu_op          (alu_op),
      .reg_we          (reg_we),
      .last_alu_result (last_alu_result),
      .retired_count   (retired_count),
      .busy            (busy),
      .halted          (halted),
      .timeout_err     (timeout_err),
      .state           (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic [15:0] instr;
      logic        done;
      logic [15:0] res;
      logic [2:0]  st;
      logic        en_pc;
      logic        start;
      logic        we;
      logic        halted;
      logic        busy;
      logic [1:0]  op;
      logic [15:0] last;
      logic [15:0] ret;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic e,
                          input logic s, input logic w, input logic h, input logic t,
                          input logic b, input logic [1:0] op, input logic [15:0] last,
                          input logic [15:0] ret);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".en_pc"}, 32'(en_pc), 32'(e));
      chk({tag, ".alu_start"}, 32'(alu_start), 32'(s));
      chk({tag, ".reg_we"}, 32'(reg_we), 32'(w));
      chk({tag, ".halted"}, 32'(halted), 32'(h));
      chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(t));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
      chk({tag, ".last"}, 32'(last_alu_result), 32'(last));
      chk({tag, ".retired"}, 32'(retired_count), 32'(ret));
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; alu_done = 1'b0; alu_result = '0; instruction_in = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // From IDLE, start and bring instr into its first EXECUTE cycle.
   task automatic to_execute(input logic [15:0] instr);
      run = 1'b1; instruction_in = instr;
      step();
      run = 1'b0;
      step();
      step();
   endtask

   initial begin
      //            run instr    done res      st      en st we h  b  op    last     ret
      vecs[0]  = '{1, 16'h0A02, 0, 16'h0000, S_FETCH, 0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd0};
      vecs[1]  = '{0, 16'h0A02, 0, 16'h0000, S_DEC,   1, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd0};
      vecs[2]  = '{0, 16'h0A02, 0, 16'h0000, S_FETCH, 0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[3]  = '{0, 16'h0010, 0, 16'h0000, S_DEC,   0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[4]  = '{0, 16'h0010, 0, 16'h0000, S_EXE,   0, 1, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[5]  = '{0, 16'h0010, 0, 16'h0000, S_EXE,   0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[6]  = '{0, 16'h0010, 0, 16'h0000, S_EXE,   0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[7]  = '{0, 16'h0010, 0, 16'h0000, S_EXE,   0, 0, 0, 0, 1, 2'd0, 16'h0000, 16'd1};
      vecs[8]  = '{0, 16'h0010, 1, 16'h0002, S_WB,    1, 0, 1, 0, 1, 2'd0, 16'h0002, 16'd1};
      vecs[9]  = '{0, 16'h0005, 0, 16'h0000, S_FETCH, 0, 0, 0, 0, 1, 2'd0, 16'h0002, 16'd2};
      vecs[10] = '{0, 16'h0005, 0, 16'h0000, S_DEC,   0, 0, 0, 0, 1, 2'd0, 16'h0002, 16'd2};
      vecs[11] = '{0, 16'h0005, 0, 16'h0000, S_EXE,   0, 1, 0, 0, 1, 2'd1, 16'h0002, 16'd2};
      vecs[12] = '{0, 16'h0005, 1, 16'h1234, S_WB,    1, 0, 1, 0, 1, 2'd0, 16'h1234, 16'd2};
      vecs[13] = '{0, 16'h0003, 1, 16'hFFFF, S_FETCH, 0, 0, 0, 0, 1, 2'd0, 16'h1234, 16'd3};
      vecs[14] = '{0, 16'h0003, 1, 16'hFFFF, S_DEC,   0, 0, 0, 0, 1, 2'd0, 16'h1234, 16'd3};
      vecs[15] = '{0, 16'h0003, 0, 16'h0000, S_HALT,  0, 0, 0, 1, 0, 2'd0, 16'h1234, 16'd3};
      vecs[16] = '{1, 16'h0010, 0, 16'h0000, S_HALT,  0, 0, 0, 1, 0, 2'd0, 16'h1234, 16'd3};
      vecs[17] = '{0, 16'h0010, 1, 16'h00AA, S_HALT,  0, 0, 0, 1, 0, 2'd0, 16'h1234, 16'd3};
      vecs[18] = '{1, 16'h0010, 0, 16'h0000, S_HALT,  0, 0, 0, 1, 0, 2'd0, 16'h1234, 16'd3};

      // Reset state, sampled while reset is still held.
      reset = 1'b1;
      step();
      chk_all("reset", S_IDLE, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0, 16'd0);
      step();
      reset = 1'b0;
      step();
      chk_all("idle_norun", S_IDLE, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0, 16'd0);

      for (int i = 0; i < NV; i++) begin
         run = vecs[i].run; instruction_in = vecs[i].instr;
         alu_done = vecs[i].done; alu_result = vecs[i].res;
         step();
         chk_all($sformatf("v%0d", i), vecs[i].st, vecs[i].en_pc, vecs[i].start,
                 vecs[i].we, vecs[i].halted, 1'b0, vecs[i].busy, vecs[i].op,
                 vecs[i].last, vecs[i].ret);
      end

      // Timeout after a prior successful op, so last_alu_result must stay 0x00AB.
      do_reset();
      to_execute(16'h0000);
      alu_done = 1'b1; alu_result = 16'h00AB;
      step();
      alu_done = 1'b0; alu_result = 16'h0000;
      step();
      instruction_in = 16'h0001;
      step();
      step();
      chk_all("to.exe1", S_EXE, 0, 1, 0, 0, 0, 1, 2'd1, 16'h00AB, 16'd1);
      for (int c = 2; c <= 15; c++) begin
         step();
         chk($sformatf("to.exe%0d.state", c), 32'(state), 32'(S_EXE));
      end
      step();
      chk_all("to.halt", S_HALT, 0, 0, 0, 1, 1, 0, 2'd0, 16'h00AB, 16'd1);
      run = 1'b1;
      step();
      chk_all("to.absorb", S_HALT, 0, 0, 0, 1, 1, 0, 2'd0, 16'h00AB, 16'd1);

      // alu_done in the very cycle the wait count hits the limit.
      do_reset();
      to_execute(16'h0010);
      for (int c = 2; c <= 15; c++) step();
      chk("edge.exe15.state", 32'(state), 32'(S_EXE));
      alu_done = 1'b1; alu_result = 16'h0055;
      step();
      alu_done = 1'b0;
      chk_all("edge.wb", S_WB, 1, 0, 1, 0, 0, 1, 2'd0, 16'h0055, 16'd0);
      step();
      chk_all("edge.fetch", S_FETCH, 0, 0, 0, 0, 0, 1, 2'd0, 16'h0055, 16'd1);

      // Five branches, then reset during the second EXECUTE cycle.
      do_reset();
      run = 1'b1; instruction_in = 16'h0002;
      step();
      run = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         step();
      end
      chk_all("rst.pre", S_FETCH, 0, 0, 0, 0, 0, 1, 2'd0, 16'h0, 16'd5);
      instruction_in = 16'h0000;
      step();
      step();
      chk("rst.exe1.start", 32'(alu_start), 32'd1);
      step();
      chk_all("rst.exe2", S_EXE, 0, 0, 0, 0, 0, 1, 2'd0, 16'h0, 16'd5);
      reset = 1'b1; alu_done = 1'b1; alu_result = 16'h7777;
      step();
      chk_all("rst.abort", S_IDLE, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0, 16'd0);
      reset = 1'b0; alu_done = 1'b0;
      step();
      chk_all("rst.after", S_IDLE, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, ALU result width.
REQ-003 SHALL have parameter ALU_TIMEOUT, default 15, the maximum number of EXECUTE cycles spent waiting for alu_done.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 run  input  1  start request; sampled only in IDLE.
REQ-008 instruction_in  input  INSTRUCTION_WIDTH  instruction currently addressed by the PC.
REQ-009 alu_done  input  1  ALU result valid this cycle.
REQ-010 alu_result  input  DATA_WIDTH  ALU result, qualified by alu_done.
REQ-011 en_pc  output  1  PC advance/branch enable, one-cycle pulse.
REQ-012 alu_start  output  1  ALU start, one-cycle pulse.
REQ-013 alu_op  output  2  ALU operation, equal to ir[1:0] while in EXECUTE.
REQ-014 reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-015 last_alu_result  output  DATA_WIDTH  last captured ALU result; feeds the branch compare in the fetch unit.
REQ-016 retired_count  output  16  count of completed instructions.
REQ-017 busy, halted, timeout_err  output  1 each  status flags.
REQ-018 state  output  3  current FSM state encoding, for debug.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT; every output SHALL be registered.
REQ-020 IDLE SHALL go to FETCH when run=1, else stay; busy=0 only in IDLE and HALT.
REQ-021 FETCH SHALL latch instruction_in into the internal ir, then go to DECODE; en_pc=0.
REQ-022 DECODE, opcode ir[1:0]=00 or 01 (ALU), SHALL go to EXECUTE.
REQ-023 DECODE, opcode 10 (branch), SHALL:
- pulse en_pc for exactly one cycle with last_alu_result held unchanged;
- increment retired_count;
- go to FETCH.
REQ-024 DECODE, opcode 11, SHALL go to HALT with halted=1; retired_count is not incremented.
REQ-025 alu_start SHALL be 1 only in the first cycle of each EXECUTE visit.
REQ-026 alu_done SHALL be honoured in any EXECUTE cycle, including the first; it is ignored in every other state.
REQ-027 On alu_done in EXECUTE, the block SHALL capture alu_result into last_alu_result and go to WRITEBACK.
REQ-028 The EXECUTE wait counter SHALL clear on EXECUTE entry and count the EXECUTE cycles without alu_done.
REQ-029 When that count reaches ALU_TIMEOUT, the block SHALL go to HALT with timeout_err=1 and halted=1, leaving last_alu_result unchanged.
REQ-030 If alu_done arrives in the same cycle the count reaches ALU_TIMEOUT, alu_done SHALL win: result captured, go to WRITEBACK.
REQ-031 WRITEBACK SHALL, for one cycle, assert reg_we=1 and en_pc=1, increment retired_count, then go to FETCH.
REQ-032 retired_count SHALL wrap from 16'hFFFF to 0.
REQ-033 HALT SHALL be absorbing until reset; run SHALL be ignored there.
REQ-034 en_pc, alu_start and reg_we SHALL never be asserted in IDLE, FETCH or HALT.

Reset
REQ-035 On reset=1 at a clock edge, from any state, the block SHALL:
- enter IDLE;
- clear ir, last_alu_result, retired_count and the wait counter;
- drive every flag and strobe to 0.
REQ-036 Reset asserted mid-EXECUTE SHALL abort the operation with no reg_we and no en_pc pulse.

Structure
REQ-037 State encoding, opcode constants (OP_ALU0=00, OP_ALU1=01, OP_BR=10, OP_HALT=11) and the default ALU_TIMEOUT SHALL live in shared package cpu_pkg.
REQ-038 The wait counter SHALL be the sub-module alu_timeout_counter (clear, enable, terminal-count output).

Verification
REQ-039 ALU op with delayed done:
- stimulus: run=1, instruction 16'h0010, alu_done 3 cycles after alu_start with alu_result=16'h0002;
- response: last_alu_result=2, one reg_we pulse, one en_pc pulse, retired_count=1, back in FETCH.
REQ-040 Branch:
- stimulus: instruction 16'h0A02 with last_alu_result=0;
- response: en_pc pulses in DECODE, last_alu_result stays 0, no alu_start, no reg_we.
REQ-041 Timeout:
- stimulus: ALU op, alu_done never asserted;
- response: HALT after exactly 15 EXECUTE cycles, timeout_err=1, halted=1, last_alu_result unchanged.
REQ-042 Done at the timeout edge:
- stimulus: alu_done in the same cycle the count reaches 15;
- response: WRITEBACK, timeout_err=0.
REQ-043 Halt opcode:
- stimulus: instruction 16'h0003, then run toggled;
- response: HALT held, halted=1, no strobes.
REQ-044 Reset mid-operation:
- stimulus: reset in the 2nd EXECUTE cycle with retired_count=5;
- response: next cycle IDLE, all outputs 0, no reg_we.
